// File: rtl/oagu_fc.sv
`timescale 1ns/1ps
// oagu_fc: FC output address generator.
// Takes FC result pieces from the PE array and buffers them in a 2-entry FIFO.
// It writes them to the IOB at StartAdder+0 .. StartAdder+N-1 and pulses
// o_StoreEnd when the vector is complete. Writes happen only on the last tiling.
module oagu_fc #(
  parameter int DATA_W  = 128,
  parameter int ADDR_W  = 12,
  parameter int PIECE_W = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [ADDR_W-1:0]  i_StartAdder,
  input  logic [PIECE_W-1:0] i_Out_PieceNum,
  input  logic               i_bLastTiling,
  input  logic               i_AGUStart,
  input  logic               i_PE_OutValid,
  input  logic [DATA_W-1:0]  i_PE_OutData,
  output logic               o_PE_OutRdy,
  input  logic               i_IOB_WBusy,
  output logic               o_IOB_WEn,
  output logic [ADDR_W-1:0]  o_IOB_WAddr,
  output logic [DATA_W-1:0]  o_IOB_WData,
  output logic               o_StoreEnd,
  output logic               o_Busy,
  output logic [1:0]         o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [ADDR_W-1:0]  r_start_addr;
  logic [PIECE_W-1:0] r_piece_num;
  logic [PIECE_W-1:0] r_in_cnt;
  logic [PIECE_W-1:0] r_wr_cnt;

  logic [DATA_W-1:0]  r_fifo_mem [2];
  logic               r_fifo_wptr;
  logic               r_fifo_rptr;
  logic [1:0]         r_fifo_cnt;

  logic               r_wen;
  logic [ADDR_W-1:0]  r_waddr;
  logic [DATA_W-1:0]  r_wdata;

  logic               w_run;
  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic               w_push;
  logic               w_pop;
  logic               w_last_pop;
  logic               w_start_go;
  logic [PIECE_W-1:0] w_wr_cnt_inc;

  // Handshake: a piece transfers on a rising edge where i_PE_OutValid and
  // o_PE_OutRdy are both 1. Ready is offered only while running, with a free
  // FIFO slot, fewer than N pieces taken, and no start pulse this cycle (a
  // piece offered alongside a start pulse is never accepted). Valid may be
  // raised or dropped freely; ready does not depend on valid.
  assign w_run        = (r_state == S_RUN);
  assign w_fifo_full  = (r_fifo_cnt == 2'd2);
  assign w_fifo_empty = (r_fifo_cnt == 2'd0);
  assign o_PE_OutRdy  = w_run & ~w_fifo_full & (r_in_cnt < r_piece_num) & ~i_AGUStart;
  assign w_push       = i_PE_OutValid & o_PE_OutRdy;
  // WBusy gives one cycle of notice: a pop now becomes a write next cycle.
  assign w_pop        = w_run & ~w_fifo_empty & ~i_IOB_WBusy & ~i_AGUStart;
  assign w_wr_cnt_inc = r_wr_cnt + 1'b1;
  assign w_last_pop   = w_pop & (w_wr_cnt_inc == r_piece_num);
  assign w_start_go   = i_bLastTiling & (i_Out_PieceNum != '0);

  assign o_IOB_WEn    = r_wen;
  assign o_IOB_WAddr  = r_waddr;
  assign o_IOB_WData  = r_wdata;
  assign o_StoreEnd   = (r_state == S_DONE);
  assign o_Busy       = (r_state != S_IDLE);
  assign o_dbg_state  = r_state;

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next state: a start pulse overrides whatever the FSM is doing.
  always_comb begin
    w_state_nxt = r_state;
    if (i_AGUStart) begin
      w_state_nxt = w_start_go ? S_RUN : S_DONE;
    end else begin
      case (r_state)
        S_RUN:   if (w_last_pop) w_state_nxt = S_DONE;
        S_DONE:  w_state_nxt = S_IDLE;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  // Job parameters and piece counters; a start resamples and clears them.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_start_addr <= '0;
      r_piece_num  <= '0;
      r_in_cnt     <= '0;
      r_wr_cnt     <= '0;
    end else if (i_AGUStart) begin
      r_start_addr <= i_StartAdder;
      r_piece_num  <= i_Out_PieceNum;
      r_in_cnt     <= '0;
      r_wr_cnt     <= '0;
    end else begin
      if (w_push) r_in_cnt <= r_in_cnt + 1'b1;
      if (w_pop)  r_wr_cnt <= w_wr_cnt_inc;
    end
  end

  // Two-entry FIFO; a start discards anything still buffered.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fifo_mem[0] <= '0;
      r_fifo_mem[1] <= '0;
      r_fifo_wptr   <= 1'b0;
      r_fifo_rptr   <= 1'b0;
      r_fifo_cnt    <= 2'd0;
    end else if (i_AGUStart) begin
      r_fifo_wptr <= 1'b0;
      r_fifo_rptr <= 1'b0;
      r_fifo_cnt  <= 2'd0;
    end else begin
      if (w_push) begin
        r_fifo_mem[r_fifo_wptr] <= i_PE_OutData;
        r_fifo_wptr             <= ~r_fifo_wptr;
      end
      if (w_pop) r_fifo_rptr <= ~r_fifo_rptr;
      case ({w_push, w_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + 2'd1;
        2'b01:   r_fifo_cnt <= r_fifo_cnt - 2'd1;
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
    end
  end

  // IOB write port: one registered write per pop; address/data hold otherwise.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wen   <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else if (i_AGUStart) begin
      r_wen <= 1'b0;
    end else if (w_pop) begin
      r_wen   <= 1'b1;
      r_waddr <= r_start_addr + ADDR_W'(r_wr_cnt);
      r_wdata <= r_fifo_mem[r_fifo_rptr];
    end else begin
      r_wen <= 1'b0;
    end
  end

endmodule

// File: tb/tb_oagu_fc.sv
`timescale 1ns/1ps
// tb_oagu_fc: randomized bench for oagu_fc with a transaction-level model.
module tb_oagu_fc;

  logic         i_clk;
  logic         i_rst_n;
  logic [11:0]  i_StartAdder;
  logic [7:0]   i_Out_PieceNum;
  logic         i_bLastTiling;
  logic         i_AGUStart;
  logic         i_PE_OutValid;
  logic [127:0] i_PE_OutData;
  logic         o_PE_OutRdy;
  logic         i_IOB_WBusy;
  logic         o_IOB_WEn;
  logic [11:0]  o_IOB_WAddr;
  logic [127:0] o_IOB_WData;
  logic         o_StoreEnd;
  logic         o_Busy;
  logic [1:0]   o_dbg_state;

  oagu_fc dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_StartAdder   (i_StartAdder),
    .i_Out_PieceNum (i_Out_PieceNum),
    .i_bLastTiling  (i_bLastTiling),
    .i_AGUStart     (i_AGUStart),
    .i_PE_OutValid  (i_PE_OutValid),
    .i_PE_OutData   (i_PE_OutData),
    .o_PE_OutRdy    (o_PE_OutRdy),
    .i_IOB_WBusy    (i_IOB_WBusy),
    .o_IOB_WEn      (o_IOB_WEn),
    .o_IOB_WAddr    (o_IOB_WAddr),
    .o_IOB_WData    (o_IOB_WData),
    .o_StoreEnd     (o_StoreEnd),
    .o_Busy         (o_Busy),
    .o_dbg_state    (o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Job phase: 0 = nothing to do, 1 = collecting/writing pieces, 2 = finished.
  int           m_phase = 0;
  logic [127:0] m_q[$];       // pieces accepted but not yet written
  int           m_in = 0;     // pieces accepted this job
  int           m_wr = 0;     // pieces written this job
  int           m_n  = 0;
  int           m_sa = 0;
  logic         m_wen = 1'b0;
  logic [11:0]  m_waddr = '0;
  logic [127:0] m_wdata = '0;

  function automatic logic exp_rdy();
    return (m_phase == 1) && (m_q.size() < 2) && (m_in < m_n) && !i_AGUStart;
  endfunction

  task automatic m_reset();
    m_phase = 0; m_q.delete(); m_in = 0; m_wr = 0; m_n = 0; m_sa = 0;
    m_wen = 1'b0; m_waddr = '0; m_wdata = '0;
  endtask

  task automatic m_step();
    logic rdy;
    logic pop;
    logic push;
    rdy = exp_rdy();
    if (i_AGUStart) begin
      m_q.delete(); m_in = 0; m_wr = 0; m_wen = 1'b0;
      m_sa = int'(i_StartAdder); m_n = int'(i_Out_PieceNum);
      m_phase = (i_bLastTiling && i_Out_PieceNum != 8'd0) ? 1 : 2;
    end else if (m_phase == 1) begin
      pop  = (m_q.size() > 0) && !i_IOB_WBusy;
      push = i_PE_OutValid && rdy;
      if (pop) begin
        m_wen   = 1'b1;
        m_waddr = 12'(m_sa + m_wr);
        m_wdata = m_q.pop_front();
        m_wr++;
      end else begin
        m_wen = 1'b0;
      end
      if (push) begin
        m_q.push_back(i_PE_OutData);
        m_in++;
      end
      if (m_wr == m_n) m_phase = 2;
    end else begin
      if (m_phase == 2) m_phase = 0;
      m_wen = 1'b0;
    end
  endtask

  initial begin
    forever begin
      @(posedge i_clk or negedge i_rst_n);
      if (!i_rst_n) m_reset();
      else          m_step();
    end
  end

  // ---------------- compare process / observation logs ----------------
  logic [11:0] wr_addr_log[$];
  int          wr_cyc_log[$];
  int          cyc_n    = 0;
  int          se_cnt   = 0;
  int          busy_cnt = 0;
  int          acc_cnt  = 0;

  initial begin
    forever begin
      @(negedge i_clk);
      #2;
      cyc_n++;
      chk("wen",      o_IOB_WEn,   m_wen);
      chk("waddr",    o_IOB_WAddr, m_waddr);
      chk("wdata",    o_IOB_WData, m_wdata);
      chk("storeend", o_StoreEnd,  m_phase == 2);
      chk("busy",     o_Busy,      m_phase != 0);
      chk("rdy",      o_PE_OutRdy, exp_rdy());
      if (o_IOB_WEn) begin
        wr_addr_log.push_back(o_IOB_WAddr);
        wr_cyc_log.push_back(cyc_n);
      end
      if (o_StoreEnd) se_cnt++;
      if (o_Busy) busy_cnt++;
      if (i_PE_OutValid && o_PE_OutRdy) acc_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge i_clk);
  endtask

  task automatic drive(input logic v, input logic b);
    i_AGUStart    = 1'b0;
    i_PE_OutValid = v;
    i_PE_OutData  = {$urandom(), $urandom(), $urandom(), $urandom()};
    i_IOB_WBusy   = b;
  endtask

  task automatic drive_rand(input int vpct, input int bpct);
    drive($urandom_range(99) < vpct, $urandom_range(99) < bpct);
  endtask

  task automatic start_pulse(input int sa, input int n, input logic last);
    drive(1'b1, 1'b0);
    i_AGUStart     = 1'b1;
    i_StartAdder   = 12'(sa);
    i_Out_PieceNum = 8'(n);
    i_bLastTiling  = last;
  endtask

  // Runs random traffic until StoreEnd is observed, then two idle cycles,
  // and checks that exactly one StoreEnd pulse was seen since se0.
  task automatic wait_done(input int se0, input int vpct, input int bpct);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (se_cnt > se0) begin
        done = 1'b1;
        break;
      end
      drive_rand(vpct, bpct);
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL job_timeout: no StoreEnd within 400 cycles at %0t", $time);
    end
    drive(1'b0, 1'b0);
    tick();
    tick();
    chk("storeend_count", se_cnt - se0, 1);
  endtask

  task automatic job(input int sa, input int n, input logic last, input int vpct, input int bpct);
    int se0;
    se0 = se_cnt;
    tick();
    start_pulse(sa, n, last);
    wait_done(se0, vpct, bpct);
  endtask

  task automatic chk_addrs(input string nm, input int w0, input int base, input int cnt);
    chk({nm, "_count"}, wr_addr_log.size() - w0, cnt);
    for (int i = 0; i < cnt && (w0 + i) < wr_addr_log.size(); i++)
      chk({nm, "_addr"}, wr_addr_log[w0 + i], 12'(base + i));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int  w0;
    int  a0;
    int  b0;
    int  se0;
    bit  hit;

    i_rst_n = 1'b1;
    i_StartAdder = '0; i_Out_PieceNum = '0; i_bLastTiling = 1'b0;
    i_AGUStart = 1'b0; i_PE_OutValid = 1'b0; i_PE_OutData = '0; i_IOB_WBusy = 1'b0;
    #1 i_rst_n = 1'b0;
    #1;
    chk("rst_wen",   o_IOB_WEn,   1'b0);
    chk("rst_waddr", o_IOB_WAddr, 12'h000);
    chk("rst_wdata", o_IOB_WData, 128'h0);
    chk("rst_se",    o_StoreEnd,  1'b0);
    chk("rst_busy",  o_Busy,      1'b0);
    chk("rst_rdy",   o_PE_OutRdy, 1'b0);
    tick(); tick();
    #3 i_rst_n = 1'b1;

    // T1: four pieces, valid every cycle, no back-pressure.
    w0 = wr_addr_log.size();
    job(12'h100, 4, 1'b1, 100, 0);
    chk_addrs("t1", w0, 12'h100, 4);
    if (wr_cyc_log.size() >= w0 + 4)
      chk("t1_back_to_back", wr_cyc_log[w0 + 3] - wr_cyc_log[w0], 3);

    // T2: WBusy for 5 cycles after the first accept.
    w0 = wr_addr_log.size(); a0 = acc_cnt; se0 = se_cnt;
    tick();
    start_pulse(12'h100, 4, 1'b1);
    hit = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (m_in >= 1) begin
        hit = 1'b1;
        break;
      end
      drive(1'b1, 1'b0);
    end
    chk("t2_first_accept", hit, 1'b1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      drive(1'b1, 1'b1);
    end
    tick();
    drive(1'b1, 1'b0);
    #3;
    chk("t2_acc_during_busy", acc_cnt - a0, 2);
    chk("t2_no_wen_busy", wr_addr_log.size() - w0, 0);
    wait_done(se0, 100, 0);
    chk_addrs("t2", w0, 12'h100, 4);

    // T3: not the last tiling -> no writes, one StoreEnd, Busy one cycle.
    w0 = wr_addr_log.size(); a0 = acc_cnt; b0 = busy_cnt;
    job(12'h000, 8, 1'b0, 100, 0);
    chk("t3_writes", wr_addr_log.size() - w0, 0);
    chk("t3_busy_cycles", busy_cnt - b0, 1);
    chk("t3_accepts", acc_cnt - a0, 0);

    // T4: address wrap.
    w0 = wr_addr_log.size();
    job(12'hFFE, 3, 1'b1, 70, 30);
    chk("t4_count", wr_addr_log.size() - w0, 3);
    if (wr_addr_log.size() >= w0 + 3) begin
      chk("t4_a0", wr_addr_log[w0],     12'hFFE);
      chk("t4_a1", wr_addr_log[w0 + 1], 12'hFFF);
      chk("t4_a2", wr_addr_log[w0 + 2], 12'h000);
    end

    // T5: restart after three writes with a piece offered on the start cycle.
    w0 = wr_addr_log.size(); se0 = se_cnt;
    tick();
    start_pulse(12'h050, 6, 1'b1);
    hit = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (m_wr >= 3) begin
        hit = 1'b1;
        break;
      end
      drive(1'b1, 1'b0);
    end
    chk("t5_three_writes", hit, 1'b1);
    start_pulse(12'h200, 2, 1'b1);
    wait_done(se0, 100, 0);
    chk("t5_count", wr_addr_log.size() - w0, 5);
    if (wr_addr_log.size() >= w0 + 5) begin
      chk("t5_a2", wr_addr_log[w0 + 2], 12'h052);
      chk("t5_a3", wr_addr_log[w0 + 3], 12'h200);
      chk("t5_a4", wr_addr_log[w0 + 4], 12'h201);
    end

    // T6: asynchronous reset in the middle of a run, then a clean job.
    tick();
    start_pulse(12'h300, 8, 1'b1);
    for (int i = 0; i < 6; i++) begin
      tick();
      drive(1'b1, 1'b0);
    end
    tick();
    #3 i_rst_n = 1'b0;
    #1;
    chk("t6_wen",   o_IOB_WEn,   1'b0);
    chk("t6_waddr", o_IOB_WAddr, 12'h000);
    chk("t6_wdata", o_IOB_WData, 128'h0);
    chk("t6_se",    o_StoreEnd,  1'b0);
    chk("t6_busy",  o_Busy,      1'b0);
    chk("t6_rdy",   o_PE_OutRdy, 1'b0);
    drive(1'b0, 1'b0);
    tick(); tick();
    #3 i_rst_n = 1'b1;
    w0 = wr_addr_log.size();
    job(12'h400, 5, 1'b1, 70, 20);
    chk_addrs("t6", w0, 12'h400, 5);

    // Random jobs, including N=0 and non-last tilings.
    for (int j = 0; j < 10; j++) begin
      job($urandom_range(4095),
          ($urandom_range(7) == 0) ? 0 : $urandom_range(1, 12),
          $urandom_range(4) != 0,
          $urandom_range(40, 100),
          $urandom_range(0, 50));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
